// File: rtl/ureg_hist_if.sv
`default_nettype none
// ============================================================================
// Module      : ureg_hist_if
// Description : Bus bundle for the ureg_hist multi-mode register.
//               Groups the control/data inputs (pre, en, mode, d, si) and
//               the register outputs (q, p, so, wrap). Clock and reset stay
//               as plain ports on the register itself.
//               master : drives pre/en/mode/d/si, observes q/p/so/wrap
//               slave  : the register side (ureg_hist)
// Revision    : 1.0 - initial release
// ============================================================================
interface ureg_hist_if #(
    parameter int WIDTH = 8
);
    logic             pre;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             si;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] p;
    logic             so;
    logic             wrap;

    modport master (
        output pre, en, mode, d, si,
        input  q, p, so, wrap
    );

    modport slave (
        input  pre, en, mode, d, si,
        output q, p, so, wrap
    );
endinterface : ureg_hist_if
`default_nettype wire

// File: rtl/ureg_hist.sv
`default_nettype none
// ============================================================================
// Module      : ureg_hist
// Description : WIDTH-bit multi-mode register with synchronous clear (ret)
//               and preset (pre), plus a HIST_DEPTH-stage history pipeline.
//               Modes: hold, load, inverted load, masked toggle, shift
//               left/right (serial in si, serial out so), count up/down
//               (one-cycle wrap pulse).
// Ports       : clk  - clock, rising edge
//               ret  - synchronous active-high clear, highest priority
//               bus  - ureg_hist_if.slave
//                      pre  : synchronous preset to PRESET_VAL
//                      en   : mode enable (0 holds q)
//                      mode : operation select
//                      d    : data / toggle mask
//                      si   : serial input for shifts
//                      q    : register value
//                      p    : q delayed by HIST_DEPTH cycles
//                      so   : bit shifted out by the last shift
//                      wrap : pulse on counter wrap
// Revision    : 1.0 - initial release
// ============================================================================
module ureg_hist #(
    parameter int               WIDTH      = 8,
    parameter int               HIST_DEPTH = 1,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  wire          clk,
    input  wire          ret,
    ureg_hist_if.slave   bus
);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_LOAD  = 3'b001;
    localparam logic [2:0] c_MODE_INV   = 3'b010;
    localparam logic [2:0] c_MODE_TOG   = 3'b011;
    localparam logic [2:0] c_MODE_SHL   = 3'b100;
    localparam logic [2:0] c_MODE_SHR   = 3'b101;
    localparam logic [2:0] c_MODE_UP    = 3'b110;
    localparam logic [2:0] c_MODE_DOWN  = 3'b111;

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_q;
    logic             r_so;
    logic             r_wrap;
    logic [WIDTH-1:0] r_hist [HIST_DEPTH];

    logic [WIDTH-1:0] w_q_next;
    logic             w_so_next;
    logic             w_wrap_next;

    // Next-state decode for everything except ret, which is handled
    // directly in the register process so it overrides all of this.
    always_comb begin
        w_q_next    = r_q;
        w_so_next   = 1'b0;
        w_wrap_next = 1'b0;
        if (bus.pre) begin
            w_q_next = PRESET_VAL;
        end else if (bus.en) begin
            case (bus.mode)
                c_MODE_HOLD: w_q_next = r_q;
                c_MODE_LOAD: w_q_next = bus.d;
                c_MODE_INV:  w_q_next = ~bus.d;
                c_MODE_TOG:  w_q_next = r_q ^ bus.d;
                c_MODE_SHL: begin
                    w_q_next  = {r_q[WIDTH-2:0], bus.si};
                    w_so_next = r_q[WIDTH-1];
                end
                c_MODE_SHR: begin
                    w_q_next  = {bus.si, r_q[WIDTH-1:1]};
                    w_so_next = r_q[0];
                end
                c_MODE_UP: begin
                    w_q_next    = r_q + c_ONE;
                    w_wrap_next = (r_q == c_ONES);
                end
                c_MODE_DOWN: begin
                    w_q_next    = r_q - c_ONE;
                    w_wrap_next = (r_q == c_ZERO);
                end
                default: w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            r_q    <= c_ZERO;
            r_so   <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_so   <= w_so_next;
            r_wrap <= w_wrap_next;
        end
    end

    // History pipeline: stage 0 captures the pre-edge q, later stages
    // simply shift. Preset and enable do not affect it; only ret clears it.
    always_ff @(posedge clk) begin
        if (ret) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= c_ZERO;
            end
        end else begin
            r_hist[0] <= r_q;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.p    = r_hist[HIST_DEPTH-1];
    assign bus.so   = r_so;
    assign bus.wrap = r_wrap;

endmodule : ureg_hist
`default_nettype wire
